// File: rtl/regwrite_scheduler_pkg.sv
// Shared register-file constants and the write-port source encoding used by the
// writeback scheduler.
package regwrite_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LOAD,
    WB_HOLD,
    WB_ALU
  } wb_src_e;

  // One-hot scoreboard mask; register 0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] a);
    reg_mask = '0;
    if (a != REG_ZERO) reg_mask[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regwrite_scheduler_if.sv
// Issue, load-response and register-file write port bundle of the writeback scheduler.
interface regwrite_scheduler_if #(
  parameter int DATA_W   = 32,
  parameter int LQ_DEPTH = 2
);
  import regwrite_scheduler_pkg::*;

  logic                      iss_valid;
  logic [REG_ADDR_W-1:0]     iss_rs;
  logic [REG_ADDR_W-1:0]     iss_rt;
  logic                      iss_use_rs;
  logic                      iss_use_rt;
  logic                      iss_wr_en;
  logic [REG_ADDR_W-1:0]     iss_wr_addr;
  logic                      iss_is_load;
  logic [DATA_W-1:0]         iss_alu_data;
  logic                      stall;
  logic                      ld_issue;
  logic                      ld_rsp_valid;
  logic [DATA_W-1:0]         ld_rsp_data;
  logic                      wb_en;
  logic [REG_ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic [NUM_REGS-1:0]       pending;
  logic [$clog2(LQ_DEPTH):0] ld_count;
  logic                      err_rsp;

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_wr_en,
           iss_wr_addr, iss_is_load, iss_alu_data, ld_rsp_valid, ld_rsp_data,
    output stall, ld_issue, wb_en, wb_addr, wb_data, pending, ld_count, err_rsp
  );

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_wr_en,
           iss_wr_addr, iss_is_load, iss_alu_data, ld_rsp_valid, ld_rsp_data,
    input  stall, ld_issue, wb_en, wb_addr, wb_data, pending, ld_count, err_rsp
  );

endinterface

// File: rtl/regwrite_scheduler_tag_fifo.sv
// In-order destination-tag FIFO for outstanding loads; push on full and pop on
// empty are ignored.
module regwrite_scheduler_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_do_push  = i_push & ~o_full;
  assign w_do_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/regwrite_scheduler.sv
// Register scoreboard and single write-port arbiter: stalls issue on RAW/WAW hazards,
// tracks in-order loads and merges load returns with ALU/JAL writebacks.
module regwrite_scheduler
  import regwrite_scheduler_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  regwrite_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic [NUM_REGS-1:0]   r_pending;
  logic                  r_hold_valid;
  logic [REG_ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0]     r_hold_data;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_err_rsp;

  logic                  w_raw_rs;
  logic                  w_raw_rt;
  logic                  w_waw;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_ld_push;
  logic [REG_ADDR_W-1:0] w_push_tag;
  logic                  w_alu_req;
  logic                  w_ld_pop;
  logic [REG_ADDR_W-1:0] w_pop_tag;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_count;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;
  wb_src_e               w_src;

  assign w_raw_rs  = bus.iss_use_rs && (bus.iss_rs != REG_ZERO) && r_pending[bus.iss_rs];
  assign w_raw_rt  = bus.iss_use_rt && (bus.iss_rt != REG_ZERO) && r_pending[bus.iss_rt];
  assign w_waw     = bus.iss_wr_en && (bus.iss_wr_addr != REG_ZERO) && r_pending[bus.iss_wr_addr];
  assign w_stall   = bus.iss_valid & (w_raw_rs | w_raw_rt | w_waw
                   | (bus.iss_is_load & w_fifo_full)
                   | (~bus.iss_is_load & bus.iss_wr_en & r_hold_valid));
  assign w_accept  = bus.iss_valid & ~w_stall;
  assign w_ld_push = w_accept & bus.iss_is_load;
  assign w_push_tag = bus.iss_wr_en ? bus.iss_wr_addr : REG_ZERO;
  assign w_alu_req = w_accept & ~bus.iss_is_load & bus.iss_wr_en & (bus.iss_wr_addr != REG_ZERO);
  assign w_ld_pop  = bus.ld_rsp_valid & ~w_fifo_empty;

  regwrite_scheduler_tag_fifo #(
    .DEPTH (LQ_DEPTH),
    .W     (REG_ADDR_W)
  ) u_tag_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_ld_push),
    .i_push_data (w_push_tag),
    .i_pop       (w_ld_pop),
    .o_pop_data  (w_pop_tag),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_src = WB_NONE;
    if (w_ld_pop)          w_src = WB_LOAD;
    else if (r_hold_valid) w_src = WB_HOLD;
    else if (w_alu_req)    w_src = WB_ALU;
  end

  // The clear follows the registered writeback, so a dependent sees the bit drop
  // one cycle after wb_en; OR-ing the set last makes a same-cycle set win.
  assign w_set = (w_ld_push ? reg_mask(w_push_tag) : '0)
               | (w_alu_req ? reg_mask(bus.iss_wr_addr) : '0);
  assign w_clr = r_wb_en ? reg_mask(r_wb_addr) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending    <= '0;
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_err_rsp    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;

      case (w_src)
        WB_LOAD: begin
          r_wb_en   <= (w_pop_tag != REG_ZERO);
          r_wb_addr <= w_pop_tag;
          r_wb_data <= bus.ld_rsp_data;
        end
        WB_HOLD: begin
          r_wb_en   <= 1'b1;
          r_wb_addr <= r_hold_addr;
          r_wb_data <= r_hold_data;
        end
        WB_ALU: begin
          r_wb_en   <= 1'b1;
          r_wb_addr <= bus.iss_wr_addr;
          r_wb_data <= bus.iss_alu_data;
        end
        default: r_wb_en <= 1'b0;
      endcase

      // A new ALU request only exists while the hold buffer is empty.
      if (w_src == WB_HOLD) r_hold_valid <= 1'b0;
      if (w_alu_req && (w_src != WB_ALU)) begin
        r_hold_valid <= 1'b1;
        r_hold_addr  <= bus.iss_wr_addr;
        r_hold_data  <= bus.iss_alu_data;
      end

      if (bus.ld_rsp_valid && w_fifo_empty) r_err_rsp <= 1'b1;
    end
  end

  assign bus.stall    = w_stall;
  assign bus.ld_issue = w_ld_push;
  assign bus.wb_en    = r_wb_en;
  assign bus.wb_addr  = r_wb_addr;
  assign bus.wb_data  = r_wb_data;
  assign bus.pending  = r_pending;
  assign bus.ld_count = w_count;
  assign bus.err_rsp  = r_err_rsp;

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Scoreboard bench for regwrite_scheduler: directed hazard scenarios plus random
// traffic checked against a queue-based model of the scheduling rules.
module tb_regwrite_scheduler;
  import regwrite_scheduler_pkg::*;

  localparam int DATA_W   = 32;
  localparam int LQ_DEPTH = 2;

  typedef struct {
    int               cyc;
    logic [4:0]       addr;
    logic [31:0]      data;
  } wb_t;

  typedef struct {
    bit          v, ld, wen, urs, urt, rv;
    logic [4:0]  wa, rs, rt;
    logic [31:0] ad, rd;
  } stim_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  regwrite_scheduler_if #(.DATA_W(DATA_W), .LQ_DEPTH(LQ_DEPTH)) bus ();

  regwrite_scheduler #(.DATA_W(DATA_W), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int  cyc     = 0;
  int  n_pass  = 0;
  int  n_total = 0;
  wb_t exp_q[$];

  // Model state: pending bitmap, outstanding load tags, hold buffer, sticky error.
  bit [31:0]  m_pend;
  logic [4:0] m_ldq[$];
  wb_t        m_hold[$];
  logic [4:0] m_prev_win;
  bit         m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit [31:0] bit_of(input logic [4:0] a);
    bit_of = '0;
    if (a != 5'd0) bit_of[a] = 1'b1;
  endfunction

  function automatic stim_t mk(input bit v, input bit ld, input bit wen, input logic [4:0] wa,
                               input logic [31:0] ad, input bit urs, input logic [4:0] rs,
                               input bit rv, input logic [31:0] rd);
    stim_t s;
    s.v = v; s.ld = ld; s.wen = wen; s.wa = wa; s.ad = ad; s.urs = urs; s.rs = rs;
    s.urt = 1'b0; s.rt = 5'd0; s.rv = rv; s.rd = rd;
    return s;
  endfunction

  task automatic drive_idle();
    bus.iss_valid = 0; bus.iss_rs = 0; bus.iss_rt = 0; bus.iss_use_rs = 0;
    bus.iss_use_rt = 0; bus.iss_wr_en = 0; bus.iss_wr_addr = 0; bus.iss_is_load = 0;
    bus.iss_alu_data = 0; bus.ld_rsp_valid = 0; bus.ld_rsp_data = 0;
  endtask

  // Called at a falling edge; drives one cycle, checks, advances the model.
  task automatic step(input stim_t s);
    bit         exp_stall, acc, alu, popped;
    bit [31:0]  nxt;
    logic [4:0] tag, win;
    wb_t        e;
    bus.iss_valid = s.v; bus.iss_is_load = s.ld; bus.iss_wr_en = s.wen;
    bus.iss_wr_addr = s.wa; bus.iss_alu_data = s.ad; bus.iss_use_rs = s.urs;
    bus.iss_rs = s.rs; bus.iss_use_rt = s.urt; bus.iss_rt = s.rt;
    bus.ld_rsp_valid = s.rv; bus.ld_rsp_data = s.rd;
    #1;
    exp_stall = s.v && ((s.urs && s.rs != 0 && m_pend[s.rs]) ||
                        (s.urt && s.rt != 0 && m_pend[s.rt]) ||
                        (s.wen && s.wa != 0 && m_pend[s.wa]) ||
                        (s.ld && m_ldq.size() == LQ_DEPTH) ||
                        (!s.ld && s.wen && m_hold.size() != 0));
    acc = s.v && !exp_stall;
    chk("stall", bus.stall, exp_stall);
    chk("ld_issue", bus.ld_issue, acc && s.ld);
    chk("pending", bus.pending, m_pend);
    chk("ld_count", bus.ld_count, m_ldq.size());
    chk("err_rsp", bus.err_rsp, m_err);

    nxt    = m_pend & ~bit_of(m_prev_win);
    win    = 5'd0;
    popped = 1'b0;
    alu    = acc && !s.ld && s.wen && s.wa != 0;
    if (s.rv) begin
      if (m_ldq.size() > 0) begin
        tag = m_ldq.pop_front();
        popped = 1'b1;
        if (tag != 0) begin
          e.cyc = cyc + 1; e.addr = tag; e.data = s.rd;
          exp_q.push_back(e);
          win = tag;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (!popped && m_hold.size() > 0) begin
      e = m_hold.pop_front();
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      win = e.addr;
    end else if (!popped && alu) begin
      e.cyc = cyc + 1; e.addr = s.wa; e.data = s.ad;
      exp_q.push_back(e);
      win = s.wa;
      alu = 1'b0;
    end
    if (alu) begin
      e.cyc = 0; e.addr = s.wa; e.data = s.ad;
      m_hold.push_back(e);
    end
    if (acc && s.ld) begin
      tag = s.wen ? s.wa : 5'd0;
      m_ldq.push_back(tag);
      nxt |= bit_of(tag);
    end
    if (acc && !s.ld && s.wen) nxt |= bit_of(s.wa);
    m_pend     = nxt;
    m_prev_win = win;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive_idle();
    m_pend = '0; m_ldq.delete(); m_hold.delete(); m_prev_win = 5'd0; m_err = 1'b0;
    exp_q.delete();
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: every registered writeback must match the head of the expected queue.
  initial begin : monitor
    wb_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (!reset) begin
        if (bus.wb_en) begin
          if (exp_q.size() == 0) begin
            chk("wb_unexpected", bus.wb_en, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_cycle", cyc, e.cyc);
            chk("wb_addr", bus.wb_addr, e.addr);
            chk("wb_data", bus.wb_data, e.data);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("wb_missing", bus.wb_en, 1'b1);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    stim_t s;
    drive_idle();
    do_reset(2);
    chk("rst_wb_en", bus.wb_en, 1'b0);
    chk("rst_wb_addr", bus.wb_addr, 5'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);

    // ALU write to r8, then a reader of r8
    step(mk(1, 0, 1, 8, 32'h11, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 8, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 8, 0, 0));

    // Load to r9 returning three cycles later while a reader waits
    step(mk(1, 1, 1, 9, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 9, 1, 32'hDEADBEEF));
    step(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));

    // Load/ALU collision on the write port, then an ALU write against a full hold
    step(mk(1, 1, 1, 4, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 1, 5, 32'h55, 0, 0, 1, 32'h44));
    step(mk(1, 0, 1, 6, 32'h66, 0, 0, 0, 0));
    step(mk(1, 0, 1, 6, 32'h66, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Tag FIFO full
    step(mk(1, 1, 1, 2, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 3, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 6, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 6, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 6, 0, 0, 0, 1, 32'h22));
    step(mk(1, 1, 1, 6, 0, 0, 0, 1, 32'h33));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h66));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Register 0 write, then WAW on r7
    step(mk(1, 0, 1, 0, 32'h99, 0, 0, 0, 0));
    step(mk(1, 1, 1, 7, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(mk(1, 0, 1, 7, 32'h7A, 0, 0, 0, 0));
    step(mk(1, 0, 1, 7, 32'h7A, 0, 0, 1, 32'h77));
    step(mk(1, 0, 1, 7, 32'h7A, 0, 0, 0, 0));
    step(mk(1, 0, 1, 7, 32'h7A, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Orphan response, then reset with a load outstanding
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD));
    step(mk(1, 1, 1, 10, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset(2);
    chk("post_rst_pending", bus.pending, 32'd0);
    chk("post_rst_ld_count", bus.ld_count, 0);
    chk("post_rst_wb_en", bus.wb_en, 1'b0);
    chk("post_rst_err", bus.err_rsp, 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset(1);

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s.v   = ($urandom_range(0, 9) < 7);
      s.ld  = ($urandom_range(0, 9) < 4);
      s.wen = ($urandom_range(0, 9) < 8);
      s.wa  = 5'($urandom_range(0, 7));
      s.urs = $urandom_range(0, 1);
      s.rs  = 5'($urandom_range(0, 7));
      s.urt = $urandom_range(0, 1);
      s.rt  = 5'($urandom_range(0, 7));
      s.ad  = $urandom;
      s.rv  = ($urandom_range(0, 9) < 4);
      s.rd  = $urandom;
      if (i == 1500) do_reset(2);
      step(s);
    end

    for (int i = 0; i < 8; i++) step(mk(0, 0, 0, 0, 0, 0, 0, (m_ldq.size() > 0), $urandom));
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
